elev_call_sched: RTL and testbench
==================================

ELEV_CALL_SCHED -- requirements
Module: elev_call_sched

Interface
REQ-001 Parameter NFLOORS, default 4, number of served floors (2..16).
REQ-002 Parameter DOOR_CYC, default 8, clock cycles door stays open per stop (>=1).
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 call_req  input  NFLOORS  hall/car call pulses, bit f = request floor f, may be held or pulsed.
REQ-006 floor_sens  input  NFLOORS  car position sensors, one-hot when car at a floor, all-zero between floors.
REQ-007 mot_up  output  1  drive motor upward.
REQ-008 mot_dn  output  1  drive motor downward.
REQ-009 door_open  output  1  door open command.
REQ-010 cur_floor  output  $clog2(NFLOORS)  last floor sensed.
REQ-011 pending  output  NFLOORS  latched outstanding calls.
REQ-012 dir_up  output  1  current scan preference, 1 = up.

Function
REQ-013 The block SHALL be a Moore FSM with states IDLE, MOVE_UP, MOVE_DN, DOOR; mot_up = (state==MOVE_UP), mot_dn = (state==MOVE_DN), door_open = (state==DOOR), all decoded from registered state.
REQ-014 pending[f] SHALL set on the cycle after call_req[f]=1 and clear only on DOOR entry at floor f; set and clear in the same cycle resolves to clear, with call absorbed.
REQ-015 IDLE, in priority order: pending[cur_floor] -> DOOR; dir_up and call above -> MOVE_UP; call below -> MOVE_DN, dir_up<=0; call above -> MOVE_UP, dir_up<=1; else remain IDLE.
REQ-016 Motor SHALL assert exactly one cycle after the IDLE decision edge; mot_up and mot_dn SHALL never be asserted together.
REQ-017 In MOVE_UP/MOVE_DN, a valid one-hot floor_sens indicating floor f != cur_floor SHALL load cur_floor<=f next edge.
REQ-018 On arrival at floor f: pending[f] -> DOOR; else f==NFLOORS-1 in MOVE_UP or f==0 in MOVE_DN -> IDLE; else no calls left in travel direction -> IDLE; else continue moving.
REQ-019 DOOR SHALL hold door_open for exactly DOOR_CYC cycles then go IDLE; a new call_req[cur_floor] during DOOR SHALL restart the count and not set pending.
REQ-020 Non-one-hot floor_sens (multiple bits) SHALL be ignored; cur_floor holds.
REQ-021 Calls to cur_floor arriving in MOVE states SHALL latch and be served after reversal.

Reset
REQ-022 On rst low: state IDLE, cur_floor 0, pending 0, dir_up 1, door count 0, mot_up/mot_dn/door_open 0, immediately and asynchronously.
REQ-023 Reset asserted mid-move SHALL stop motor immediately; calls are discarded.

Configuration
REQ-024 Macro ELEV_CALL_SCHED_ESTOP_EN present: extra input estop (1 bit, active-high) forces state IDLE and motors/door off while high, pending retained, scheduling resumes the cycle after release.
REQ-025 Macro absent: no estop port, no related logic.

Structure
REQ-026 Package elev_pkg SHALL hold the state enum (IDLE, MOVE_UP, MOVE_DN, DOOR) and direction constants DIR_UP/DIR_DN.
REQ-027 Door countdown SHALL be sub-module elev_door_timer (load, restart, done) instantiated once.

Verification
REQ-028 Reset, call_req=4'b1000 pulse, sensors walk 1,2,3 -> mot_up from cycle 2, stop at floor 3, door_open 8 cycles, pending=0, IDLE.
REQ-029 At floor 3 dir_up=1, calls floors 0 and 2 same cycle -> MOVE_DN, door at 2, then continue, door at 0.
REQ-030 IDLE at floor 1, call_req[1] -> DOOR next cycle, no motor pulse; repeat call on cycle 5 of door -> door_open total 13 cycles.
REQ-031 floor_sens=4'b0110 during MOVE_UP -> cur_floor unchanged, motor continues.
REQ-032 rst low while mot_up=1 -> mot_up 0 same cycle, pending 0, cur_floor 0.
REQ-033 With ELEV_CALL_SCHED_ESTOP_EN: estop during MOVE_UP -> motor off next edge, pending kept, motion resumes after release.

Source files
------------

// File: rtl/elev_pkg.sv
// Shared types for the elevator call scheduler: FSM state encoding and scan direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/elev_door_timer.sv
// Door dwell countdown: load/restart arm DOOR_CYC cycles, done flags the final open cycle.
// Latency: done asserts DOOR_CYC-1 cycles after the load edge.
// Backpressure: none; restart re-arms and masks done in the same cycle.
module elev_door_timer #(
    parameter int DOOR_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic restart,
    output logic done
);

    localparam int CW = $clog2(DOOR_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load || restart) begin
            cnt <= CW'(DOOR_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == CW'(1)) && !restart;

endmodule

// File: rtl/elev_call_sched.sv
// Single-car elevator call scheduler: Moore FSM latching calls and scanning up/down between floors.
// Latency: calls latch one edge after call_req; motor/door change one edge after the decision.
// Backpressure: none; ELEV_CALL_SCHED_ESTOP_EN adds an estop input that parks the car in IDLE.
module elev_call_sched
    import elev_pkg::*;
#(
    parameter int NFLOORS  = 4,
    parameter int DOOR_CYC = 8
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef ELEV_CALL_SCHED_ESTOP_EN
    input  logic                       estop,
`endif
    input  logic [NFLOORS-1:0]         call_req,
    input  logic [NFLOORS-1:0]         floor_sens,
    output logic                       mot_up,
    output logic                       mot_dn,
    output logic                       door_open,
    output logic [$clog2(NFLOORS)-1:0] cur_floor,
    output logic [NFLOORS-1:0]         pending,
    output logic                       dir_up
);

    localparam int FW   = $clog2(NFLOORS);
    localparam int CNTW = $clog2(NFLOORS + 1);
    localparam logic [FW-1:0] TOP = FW'(NFLOORS - 1);

    state_t             state, state_nxt;
    logic [FW-1:0]      floor_nxt;
    logic [NFLOORS-1:0] pend_nxt;
    logic [NFLOORS-1:0] req_mask;
    logic [NFLOORS-1:0] clr;
    logic               dir_nxt;
    logic               door_load;
    logic               door_restart;
    logic               door_done;

    logic [CNTW-1:0]    sens_cnt;
    logic [FW-1:0]      sens_idx;
    logic               sens_vld;

    function automatic logic any_above(input logic [NFLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (i > int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NFLOORS-1:0] p, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (i < int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    // Sensor decode: only an exactly-one-hot pattern counts as a floor.
    always_comb begin
        sens_cnt = '0;
        sens_idx = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (floor_sens[i]) begin
                sens_cnt = sens_cnt + CNTW'(1);
                sens_idx = FW'(i);
            end
        end
    end

    assign sens_vld = (sens_cnt == CNTW'(1));

    elev_door_timer #(
        .DOOR_CYC (DOOR_CYC)
    ) u_door_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (door_load),
        .restart (door_restart),
        .done    (door_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        floor_nxt    = cur_floor;
        dir_nxt      = dir_up;
        clr          = '0;
        req_mask     = call_req;
        door_load    = 1'b0;
        door_restart = 1'b0;
        case (state)
            IDLE: begin
                if (pending[cur_floor]) begin
                    state_nxt      = DOOR;
                    clr[cur_floor] = 1'b1;
                    door_load      = 1'b1;
                end else if (dir_up && any_above(pending, cur_floor)) begin
                    state_nxt = MOVE_UP;
                end else if (any_below(pending, cur_floor)) begin
                    state_nxt = MOVE_DN;
                    dir_nxt   = DIR_DN;
                end else if (any_above(pending, cur_floor)) begin
                    state_nxt = MOVE_UP;
                    dir_nxt   = DIR_UP;
                end
            end
            MOVE_UP, MOVE_DN: begin
                // The floor just left stays asserted briefly; only a new floor is an arrival.
                if (sens_vld && sens_idx != cur_floor) begin
                    floor_nxt = sens_idx;
                    if (pending[sens_idx]) begin
                        state_nxt     = DOOR;
                        clr[sens_idx] = 1'b1;
                        door_load     = 1'b1;
                    end else if (state == MOVE_UP && sens_idx == TOP) begin
                        state_nxt = IDLE;
                    end else if (state == MOVE_DN && sens_idx == '0) begin
                        state_nxt = IDLE;
                    end else if (state == MOVE_UP && !any_above(pending, sens_idx)) begin
                        state_nxt = IDLE;
                    end else if (state == MOVE_DN && !any_below(pending, sens_idx)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR: begin
                if (call_req[cur_floor]) begin
                    door_restart        = 1'b1;
                    req_mask[cur_floor] = 1'b0;
                end else if (door_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef ELEV_CALL_SCHED_ESTOP_EN
        if (estop) begin
            state_nxt    = IDLE;
            floor_nxt    = cur_floor;
            dir_nxt      = dir_up;
            clr          = '0;
            req_mask     = call_req;
            door_load    = 1'b0;
            door_restart = 1'b0;
        end
`endif
    end

    // A call arriving on the edge its floor is served is absorbed by the clear.
    assign pend_nxt = (pending | req_mask) & ~clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_floor <= '0;
            pending   <= '0;
            dir_up    <= DIR_UP;
        end else begin
            cur_floor <= floor_nxt;
            pending   <= pend_nxt;
            dir_up    <= dir_nxt;
        end
    end

    always_comb begin
        mot_up    = (state == MOVE_UP);
        mot_dn    = (state == MOVE_DN);
        door_open = (state == DOOR);
    end

endmodule

// File: tb/tb_elev_call_sched.sv
// Directed scoreboard bench for elev_call_sched (NFLOORS=4, DOOR_CYC=8).
module tb_elev_call_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] call_req = 4'b0000;
    logic [3:0] floor_sens = 4'b0001;
    logic       mot_up, mot_dn, door_open, dir_up;
    logic [1:0] cur_floor;
    logic [3:0] pending;
`ifdef ELEV_CALL_SCHED_ESTOP_EN
    logic       estop = 1'b0;
`endif

    int         compared = 0;
    int         mismatched = 0;
    string      name_q[$];
    logic [9:0] exp_q[$];
    int         door_q[$];
    int         door_run = 0;
    int         door_exp;
    logic       probe = 1'b0;
    string      mon_n;
    logic [9:0] mon_e;
    logic [9:0] obs;

    always #5 clk = ~clk;

    elev_call_sched #(
        .NFLOORS  (4),
        .DOOR_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ELEV_CALL_SCHED_ESTOP_EN
        .estop      (estop),
`endif
        .call_req   (call_req),
        .floor_sens (floor_sens),
        .mot_up     (mot_up),
        .mot_dn     (mot_dn),
        .door_open  (door_open),
        .cur_floor  (cur_floor),
        .pending    (pending),
        .dir_up     (dir_up)
    );

    assign obs = {mot_up, mot_dn, door_open, cur_floor, pending, dir_up};

    function automatic logic [9:0] ev(input logic mu, input logic md, input logic dr,
                                      input logic [1:0] f, input logic [3:0] p, input logic d);
        return {mu, md, dr, f, p, d};
    endfunction

    task automatic expect_st(input string n, input logic [9:0] e);
        name_q.push_back(n);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops every queued expectation at the sample point.
    always @(negedge clk or posedge probe) begin
        while (exp_q.size() > 0) begin
            mon_n = name_q.pop_front();
            mon_e = exp_q.pop_front();
            compared++;
            if (obs !== mon_e) begin
                mismatched++;
                $display("FAIL %s: actual %b required %b (up,dn,door,floor[1:0],pend[3:0],dir)",
                         mon_n, obs, mon_e);
            end
        end
        compared++;
        if (mot_up && mot_dn) begin
            mismatched++;
            $display("FAIL motor_excl: actual up=%b dn=%b required not both", mot_up, mot_dn);
        end
    end

    // Door dwell monitor: measures each door_open run and checks it against the queue.
    always @(negedge clk) begin
        if (door_open) begin
            door_run++;
        end else if (door_run > 0) begin
            compared++;
            if (door_q.size() == 0) begin
                mismatched++;
                $display("FAIL door_len: actual %0d cycles required no door opening", door_run);
            end else begin
                door_exp = door_q.pop_front();
                if (door_run != door_exp) begin
                    mismatched++;
                    $display("FAIL door_len: actual %0d cycles required %0d", door_run, door_exp);
                end
            end
            door_run = 0;
        end
    end

    initial begin
        #1;
        expect_st("reset_state", ev(0, 0, 0, 2'd0, 4'b0000, 1));
        tick(2);
        rst = 1'b1;
        call_req = 4'b1000;
        expect_st("t1_pre_latch", ev(0, 0, 0, 2'd0, 4'b0000, 1));
        tick();
        call_req = 4'b0000;
        expect_st("t1_latch", ev(0, 0, 0, 2'd0, 4'b1000, 1));
        tick();
        expect_st("t1_up", ev(1, 0, 0, 2'd0, 4'b1000, 1));
        floor_sens = 4'b0000;
        tick();
        floor_sens = 4'b0010;
        tick();
        expect_st("t1_floor1", ev(1, 0, 0, 2'd1, 4'b1000, 1));
        floor_sens = 4'b0110;
        tick();
        expect_st("t1_multi_ignored", ev(1, 0, 0, 2'd1, 4'b1000, 1));
        floor_sens = 4'b0100;
        tick();
        expect_st("t1_floor2", ev(1, 0, 0, 2'd2, 4'b1000, 1));
        floor_sens = 4'b1000;
        tick();
        door_q.push_back(8);
        expect_st("t1_door3", ev(0, 0, 1, 2'd3, 4'b0000, 1));
        tick(8);
        expect_st("t1_idle3", ev(0, 0, 0, 2'd3, 4'b0000, 1));

        call_req = 4'b0101;
        tick();
        call_req = 4'b0000;
        expect_st("t2_latch", ev(0, 0, 0, 2'd3, 4'b0101, 1));
        tick();
        expect_st("t2_down", ev(0, 1, 0, 2'd3, 4'b0101, 0));
        floor_sens = 4'b0100;
        tick();
        door_q.push_back(8);
        expect_st("t2_door2", ev(0, 0, 1, 2'd2, 4'b0001, 0));
        tick(8);
        expect_st("t2_idle2", ev(0, 0, 0, 2'd2, 4'b0001, 0));
        tick();
        expect_st("t2_down_again", ev(0, 1, 0, 2'd2, 4'b0001, 0));
        floor_sens = 4'b0010;
        tick();
        expect_st("t2_pass1", ev(0, 1, 0, 2'd1, 4'b0001, 0));
        floor_sens = 4'b0001;
        tick();
        door_q.push_back(8);
        expect_st("t2_door0", ev(0, 0, 1, 2'd0, 4'b0000, 0));
        tick(8);
        expect_st("t2_idle0", ev(0, 0, 0, 2'd0, 4'b0000, 0));

        call_req = 4'b0010;
        tick();
        call_req = 4'b0000;
        tick();
        expect_st("t3_up_reverse", ev(1, 0, 0, 2'd0, 4'b0010, 1));
        floor_sens = 4'b0010;
        tick();
        door_q.push_back(8);
        expect_st("t3_door1", ev(0, 0, 1, 2'd1, 4'b0000, 1));
        tick(8);
        expect_st("t3_idle1", ev(0, 0, 0, 2'd1, 4'b0000, 1));
        call_req = 4'b0010;
        tick();
        call_req = 4'b0000;
        expect_st("t3_latch_no_motor", ev(0, 0, 0, 2'd1, 4'b0010, 1));
        tick();
        door_q.push_back(13);
        expect_st("t3_door_here", ev(0, 0, 1, 2'd1, 4'b0000, 1));
        tick(4);
        call_req = 4'b0010;
        tick();
        call_req = 4'b0000;
        expect_st("t3_restart_no_pend", ev(0, 0, 1, 2'd1, 4'b0000, 1));
        tick(8);
        expect_st("t3_idle_after_13", ev(0, 0, 0, 2'd1, 4'b0000, 1));

        call_req = 4'b1000;
        tick();
        call_req = 4'b0000;
        tick();
        expect_st("t4_up", ev(1, 0, 0, 2'd1, 4'b1000, 1));
        call_req = 4'b0010;
        tick();
        call_req = 4'b0000;
        expect_st("t4_curfloor_latched", ev(1, 0, 0, 2'd1, 4'b1010, 1));
        @(negedge clk);
        #1;
        rst = 1'b0;
        expect_st("t4_async_reset", ev(0, 0, 0, 2'd0, 4'b0000, 1));
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        tick();
        rst = 1'b1;
        floor_sens = 4'b0001;
        call_req = 4'b0001;
        expect_st("t5_post_reset", ev(0, 0, 0, 2'd0, 4'b0000, 1));
        tick();
        tick();
        call_req = 4'b0000;
        door_q.push_back(8);
        expect_st("t5_set_clear_collide", ev(0, 0, 1, 2'd0, 4'b0000, 1));
        tick(8);
        expect_st("t5_idle", ev(0, 0, 0, 2'd0, 4'b0000, 1));

`ifdef ELEV_CALL_SCHED_ESTOP_EN
        call_req = 4'b0100;
        tick();
        call_req = 4'b0000;
        tick();
        expect_st("t6_up", ev(1, 0, 0, 2'd0, 4'b0100, 1));
        estop = 1'b1;
        tick();
        expect_st("t6_estop_stop", ev(0, 0, 0, 2'd0, 4'b0100, 1));
        tick();
        expect_st("t6_estop_hold", ev(0, 0, 0, 2'd0, 4'b0100, 1));
        estop = 1'b0;
        tick();
        expect_st("t6_resume", ev(1, 0, 0, 2'd0, 4'b0100, 1));
        floor_sens = 4'b0100;
        tick();
        door_q.push_back(8);
        expect_st("t6_door2", ev(0, 0, 1, 2'd2, 4'b0000, 1));
        tick(8);
        expect_st("t6_idle2", ev(0, 0, 0, 2'd2, 4'b0000, 1));
`endif

        tick(2);
        compared++;
        if (door_q.size() != 0 || door_run != 0) begin
            mismatched++;
            $display("FAIL door_drain: actual %0d queued / run %0d required 0 / 0",
                     door_q.size(), door_run);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
